// File: rtl/alu_pkg.sv
// Shared encodings for the RISC-V ALU control decoder.
// Covers the ALU operation codes, the main-decoder ALU classes and the funct3 values.
package alu_pkg;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b100,
        ALU_XOR = 3'b101,
        ALU_SRL = 3'b110,
        ALU_SLL = 3'b111
    } alu_ctrl_t;

    typedef enum logic [1:0] {
        LDST   = 2'b00,
        BRANCH = 2'b01,
        RTYPE  = 2'b10,
        RSVD   = 2'b11
    } alu_op_t;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SRL  = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

endpackage

// File: rtl/alu_decoder_if.sv
// Bundle between the main decoder (master) and the ALU control decoder (slave).
interface alu_decoder_if;
    logic [1:0] aluOp;
    logic [2:0] funct3;
    logic       funct7_5;
    logic [2:0] ALUControl;
    logic [2:0] ALUControlQ;
    logic       illegal;
    logic       illegalSeen;

    modport master (
        output aluOp, funct3, funct7_5,
        input  ALUControl, ALUControlQ, illegal, illegalSeen
    );

    modport slave (
        input  aluOp, funct3, funct7_5,
        output ALUControl, ALUControlQ, illegal, illegalSeen
    );
endinterface

// File: rtl/alu_decode_comb.sv
// Pure combinational mapping of aluOp/funct3/funct7[5] to the ALU operation code.
// Any encoding that is reserved, unsupported or not fully known gives ADD with illegal raised.
module alu_decode_comb
    import alu_pkg::*;
(
    input  logic [1:0] alu_op_i,
    input  logic [2:0] funct3_i,
    input  logic       funct7_5_i,
    output logic [2:0] alu_ctrl_o,
    output logic       illegal_o
);

    alu_ctrl_t alu_ctrl;
    logic      illegal;

    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
        alu_ctrl = ALU_ADD;
        illegal  = 1'b1;
        // Ranges cover the ignored bits without wildcards, so X/Z inputs match nothing and reach default.
        case ({alu_op_i, funct3_i, funct7_5_i}) inside
            [{LDST, 4'b0000}   : {LDST, 4'b1111}]:   begin alu_ctrl = ALU_ADD; illegal = 1'b0; end
            [{BRANCH, 4'b0000} : {BRANCH, 4'b1111}]: begin alu_ctrl = ALU_SUB; illegal = 1'b0; end
            {RTYPE, F3_ADD, 1'b0}:                   begin alu_ctrl = ALU_ADD; illegal = 1'b0; end
            {RTYPE, F3_ADD, 1'b1}:                   begin alu_ctrl = ALU_SUB; illegal = 1'b0; end
            [{RTYPE, F3_AND, 1'b0} : {RTYPE, F3_AND, 1'b1}]: begin alu_ctrl = ALU_AND; illegal = 1'b0; end
            [{RTYPE, F3_OR,  1'b0} : {RTYPE, F3_OR,  1'b1}]: begin alu_ctrl = ALU_OR;  illegal = 1'b0; end
            [{RTYPE, F3_SLT, 1'b0} : {RTYPE, F3_SLT, 1'b1}]: begin alu_ctrl = ALU_SLT; illegal = 1'b0; end
            [{RTYPE, F3_XOR, 1'b0} : {RTYPE, F3_XOR, 1'b1}]: begin alu_ctrl = ALU_XOR; illegal = 1'b0; end
            [{RTYPE, F3_SRL, 1'b0} : {RTYPE, F3_SRL, 1'b1}]: begin alu_ctrl = ALU_SRL; illegal = 1'b0; end
            [{RTYPE, F3_SLL, 1'b0} : {RTYPE, F3_SLL, 1'b1}]: begin alu_ctrl = ALU_SLL; illegal = 1'b0; end
            default: ; // RTYPE/SLTU and RSVD keep the ADD + illegal defaults
        endcase
    end

    assign alu_ctrl_o = alu_ctrl;
    assign illegal_o  = illegal;

endmodule

// File: rtl/alu_decoder.sv
// Second-level ALU control decoder: combinational code plus registered
// copies of the code and a sticky illegal-encoding flag for trace.
module alu_decoder
    import alu_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    alu_decoder_if.slave  bus
);

    logic [2:0] alu_ctrl_d, alu_ctrl_q;
    logic       illegal_seen_d, illegal_seen_q;

    alu_decode_comb u_decode (
        .alu_op_i   (bus.aluOp),
        .funct3_i   (bus.funct3),
        .funct7_5_i (bus.funct7_5),
        .alu_ctrl_o (bus.ALUControl),
        .illegal_o  (bus.illegal)
    );

    assign alu_ctrl_d     = bus.ALUControl;
    assign illegal_seen_d = illegal_seen_q | bus.illegal;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_ctrl_q     <= ALU_ADD;
            illegal_seen_q <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            alu_ctrl_q     <= alu_ctrl_d;
            illegal_seen_q <= illegal_seen_d;
        end
    end

    assign bus.ALUControlQ = alu_ctrl_q;
    assign bus.illegalSeen = illegal_seen_q;

endmodule

// File: tb/tb_alu_decoder.sv
// Directed and exhaustive checks of the ALU control decoder and its trace registers.
module tb_alu_decoder;

    logic clk    = 1'b0;
    logic clk_en = 1'b1;
    logic rst_n  = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    alu_decoder_if bus ();

    alu_decoder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    typedef struct {
        logic [1:0] op;
        logic [2:0] f3;
        logic       f7;
        logic [2:0] ctrl;
        logic       ill;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void add(logic [1:0] op, logic [2:0] f3, logic f7, logic [2:0] ctrl, logic ill);
        vec_t v;
        v.op = op; v.f3 = f3; v.f7 = f7; v.ctrl = ctrl; v.ill = ill;
        vecs.push_back(v);
    endfunction

    // Reference written as an R-type lookup table, independent of the RTL case structure.
    function automatic logic [3:0] model(logic [1:0] op, logic [2:0] f3, logic f7);
        logic [2:0] rtbl [8];
        rtbl = '{3'd0, 3'd7, 3'd4, 3'd0, 3'd5, 3'd6, 3'd3, 3'd2};
        if (op == 2'd0) return 4'b0_000;
        if (op == 2'd1) return 4'b0_001;
        if (op == 2'd3) return 4'b1_000;
        if (f3 == 3'd3) return 4'b1_000;
        if (f3 == 3'd0 && f7) return 4'b0_001;
        return {1'b0, rtbl[f3]};
    endfunction

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic       seen_exp;
        logic [2:0] q_saved;
        logic [3:0] m;

        bus.aluOp = 2'b00; bus.funct3 = 3'b000; bus.funct7_5 = 1'b0;

        // Load/store and branch ignore the funct fields
        add(2'b00, 3'b000, 1'b0, 3'b000, 1'b0);
        add(2'b00, 3'b111, 1'b1, 3'b000, 1'b0);
        add(2'b00, 3'b000, 1'b1, 3'b000, 1'b0);
        add(2'b00, 3'b111, 1'b0, 3'b000, 1'b0);
        add(2'b01, 3'b000, 1'b0, 3'b001, 1'b0);
        add(2'b01, 3'b111, 1'b1, 3'b001, 1'b0);
        add(2'b10, 3'b000, 1'b0, 3'b000, 1'b0);
        add(2'b10, 3'b000, 1'b1, 3'b001, 1'b0);
        for (int f = 0; f < 2; f++) begin
            add(2'b10, 3'b111, f[0], 3'b010, 1'b0);
            add(2'b10, 3'b110, f[0], 3'b011, 1'b0);
            add(2'b10, 3'b010, f[0], 3'b100, 1'b0);
            add(2'b10, 3'b100, f[0], 3'b101, 1'b0);
            add(2'b10, 3'b101, f[0], 3'b110, 1'b0);
            add(2'b10, 3'b001, f[0], 3'b111, 1'b0);
        end
        add(2'b10, 3'b011, 1'b0, 3'b000, 1'b1);
        add(2'b11, 3'b101, 1'b1, 3'b000, 1'b1);
        add(2'b11, 3'b000, 1'b0, 3'b000, 1'b1);
        add(2'b10, 3'b110, 1'b0, 3'b011, 1'b0);
        add(2'b10, 3'b001, 1'b0, 3'b111, 1'b0);

        #1;
        check("reset_q",    {1'b0, bus.ALUControlQ}, 4'h0);
        check("reset_seen", {3'b0, bus.illegalSeen}, 4'h0);
        @(negedge clk);
        rst_n = 1'b1;

        seen_exp = 1'b0;
        foreach (vecs[i]) begin
            @(negedge clk);
            bus.aluOp = vecs[i].op; bus.funct3 = vecs[i].f3; bus.funct7_5 = vecs[i].f7;
            #1;
            check($sformatf("v%0d_ctrl", i), {1'b0, bus.ALUControl}, {1'b0, vecs[i].ctrl});
            check($sformatf("v%0d_ill", i),  {3'b0, bus.illegal},    {3'b0, vecs[i].ill});
            @(posedge clk);
            #1;
            seen_exp = seen_exp | vecs[i].ill;
            check($sformatf("v%0d_q", i),    {1'b0, bus.ALUControlQ}, {1'b0, vecs[i].ctrl});
            check($sformatf("v%0d_seen", i), {3'b0, bus.illegalSeen}, {3'b0, seen_exp});
        end

        // Registered path: Q holds SLL until the edge, then follows OR
        @(negedge clk);
        bus.aluOp = 2'b10; bus.funct3 = 3'b110; bus.funct7_5 = 1'b0;
        #1;
        check("q_before_edge", {1'b0, bus.ALUControlQ}, 4'h7);
        @(posedge clk);
        #1;
        check("q_after_edge", {1'b0, bus.ALUControlQ}, 4'h3);

        // Asynchronous reset between edges
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_q",    {1'b0, bus.ALUControlQ}, 4'h0);
        check("async_rst_seen", {3'b0, bus.illegalSeen}, 4'h0);
        check("rst_comb_ctrl",  {1'b0, bus.ALUControl},  4'h3);
        check("rst_comb_ill",   {3'b0, bus.illegal},     4'h0);
        @(posedge clk);
        #1;
        check("rst_hold_q", {1'b0, bus.ALUControlQ}, 4'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_release_q", {1'b0, bus.ALUControlQ}, 4'h0);
        @(posedge clk);
        #1;
        check("post_rst_q",    {1'b0, bus.ALUControlQ}, 4'h3);
        check("post_rst_seen", {3'b0, bus.illegalSeen}, 4'h0);

        // Exhaustive sweep with the clock stopped
        @(negedge clk);
        clk_en  = 1'b0;
        q_saved = bus.ALUControlQ;
        for (int i = 0; i < 64; i++) begin
            logic [5:0] sel;
            sel = i[5:0];
            bus.aluOp = sel[5:4]; bus.funct3 = sel[3:1]; bus.funct7_5 = sel[0];
            #1;
            m = model(sel[5:4], sel[3:1], sel[0]);
            check($sformatf("sweep%0d_ctrl", i), {1'b0, bus.ALUControl}, {1'b0, m[2:0]});
            check($sformatf("sweep%0d_ill", i),  {3'b0, bus.illegal},    {3'b0, m[3]});
        end
        check("sweep_q_stable",    {1'b0, bus.ALUControlQ}, {1'b0, q_saved});
        check("sweep_seen_stable", {3'b0, bus.illegalSeen}, 4'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
